// File: rtl/vmode_switch_ctrl.sv
// rtl/vmode_switch_ctrl.sv - frame-aligned video clock mode switch sequencer
// Blanks and resets the video pipeline around a clock-select change taken at vsync.
module vmode_switch_ctrl #(
   parameter int BLANK_CYCLES  = 16,
   parameter int SETTLE_CYCLES = 64,
   parameter int VSYNC_TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic req_valid,
   input  logic req_mode,
   input  logic vsync_pulse,
   output logic video_mode,
   output logic video_blank,
   output logic video_rst,
   output logic busy,
   output logic done
);

   localparam logic [23:0] BLANK_LOAD   = 24'(BLANK_CYCLES - 1);
   localparam logic [23:0] SETTLE_LOAD  = 24'(SETTLE_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_LOAD = 24'(VSYNC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_VSYNC,
      BLANK,
      SWITCH,
      SETTLE,
      RELEASE
   } state_t;

   state_t      state;
   logic        target;
   logic        pend_valid;
   logic        pend_mode;
   logic [23:0] cnt;

   logic        take;
   logic        take_mode;

   // A fresh request is newer than anything pending, so it takes priority.
   always_comb begin
      take      = 1'b0;
      take_mode = 1'b0;
      if (req_valid) begin
         take      = 1'b1;
         take_mode = req_mode;
      end else if (pend_valid) begin
         take      = 1'b1;
         take_mode = pend_mode;
      end
   end

   assign busy = (state != IDLE) | pend_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         target      <= 1'b0;
         pend_valid  <= 1'b0;
         pend_mode   <= 1'b0;
         cnt         <= 24'd0;
         video_mode  <= 1'b0;
         video_blank <= 1'b0;
         video_rst   <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  pend_valid <= 1'b0;
                  if (take_mode == video_mode) begin
                     done <= 1'b1;
                  end else begin
                     target <= take_mode;
                     cnt    <= TIMEOUT_LOAD;
                     state  <= WAIT_VSYNC;
                  end
               end
            end
            WAIT_VSYNC: begin
               if (vsync_pulse || cnt == 24'd0) begin
                  video_blank <= 1'b1;
                  cnt         <= BLANK_LOAD;
                  state       <= BLANK;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            BLANK: begin
               if (cnt == 24'd0) begin
                  video_rst <= 1'b1;
                  state     <= SWITCH;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            SWITCH: begin
               // Blank and reset are both already high here, so the mux change is invisible.
               video_mode <= target;
               cnt        <= SETTLE_LOAD;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (cnt == 24'd0) begin
                  video_rst <= 1'b0;
                  state     <= RELEASE;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            RELEASE: begin
               video_blank <= 1'b0;
               done        <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (state != IDLE && req_valid) begin
            pend_valid <= 1'b1;
            pend_mode  <= req_mode;
         end
      end
   end

endmodule

// File: tb/tb_vmode_switch_ctrl.sv
// tb/tb_vmode_switch_ctrl.sv - scoreboard bench for vmode_switch_ctrl
// A timestamp-based reference model predicts every output cycle; a monitor compares.
module tb_vmode_switch_ctrl;

   localparam int B = 4;
   localparam int S = 8;
   localparam int T = 100;

   logic clk = 1'b0;
   logic reset;
   logic req_valid;
   logic req_mode;
   logic vsync_pulse;
   logic video_mode;
   logic video_blank;
   logic video_rst;
   logic busy;
   logic done;

   vmode_switch_ctrl #(
      .BLANK_CYCLES (B),
      .SETTLE_CYCLES(S),
      .VSYNC_TIMEOUT(T)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_mode   (req_mode),
      .vsync_pulse(vsync_pulse),
      .video_mode (video_mode),
      .video_blank(video_blank),
      .video_rst  (video_rst),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic mode;
      logic blank;
      logic rst;
      logic busy;
      logic done;
   } vec_t;

   vec_t exp_q[$];
   int   k = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: a sequence is described by when it started waiting and
   // the cycle blank rose; every other edge is an offset from that cycle.
   bit m_seq, m_wait, m_tgt, m_mode, m_pv, m_pm;
   int m_wait_start = 0;
   int m_b_at = -1000;
   int m_same_done = -1;

   task automatic step(input bit rs, input bit rv, input bit rm, input bit vs);
      vec_t e;
      int   n;
      int   done_at;
      bit   have;
      bit   hm;
      reset       = rs;
      req_valid   = rv;
      req_mode    = rm;
      vsync_pulse = vs;
      n = k + 1;
      e = '0;
      if (rs) begin
         m_seq       = 0;
         m_wait      = 0;
         m_tgt       = 0;
         m_mode      = 0;
         m_pv        = 0;
         m_pm        = 0;
         m_same_done = -1;
         m_b_at      = -1000;
      end else begin
         done_at = m_b_at + B + 2 + S;
         if (m_seq && !m_wait && k >= done_at) m_seq = 0;
         if (!m_seq) begin
            have = 0;
            hm   = 0;
            if (rv) begin
               have = 1; hm = rm; m_pv = 0;
            end else if (m_pv) begin
               have = 1; hm = m_pm; m_pv = 0;
            end
            if (have) begin
               if (hm == m_mode) m_same_done = n;
               else begin
                  m_seq = 1; m_wait = 1; m_wait_start = n; m_tgt = hm;
               end
            end
         end else begin
            if (rv) begin
               m_pv = 1; m_pm = rm;
            end
            if (m_wait && (vs || k == m_wait_start + T - 1)) begin
               m_wait = 0;
               m_b_at = n;
            end
         end
         done_at = m_b_at + B + 2 + S;
         if (m_seq && !m_wait && n == m_b_at + B + 1) m_mode = m_tgt;
         e.mode  = m_mode;
         e.blank = m_seq && !m_wait && n >= m_b_at && n < done_at;
         e.rst   = m_seq && !m_wait && n >= m_b_at + B && n < m_b_at + B + 1 + S;
         e.done  = (m_same_done == n) || (m_seq && !m_wait && n == done_at);
         e.busy  = (m_seq && (m_wait || n < done_at)) || m_pv;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
   endtask

   vec_t mon_e;
   vec_t mon_a;

   always @(negedge clk) begin
      if ($time > 0 && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {video_mode, video_blank, video_rst, busy, done};
         n_vec++;
         if (mon_a !== mon_e) begin
            n_bad++;
            $display("FAIL outputs t=%0t mode/blank/rst/busy/done got %b required %b",
                     $time, mon_a, mon_e);
         end
      end
   end

   initial begin
      // Scenario 1: request at cycle 10, vsync at cycle 20.
      do_reset();
      idle(8);
      step(0, 1, 1, 0);
      idle(9);
      step(0, 0, 0, 1);
      idle(20);

      // Scenario 2: no vsync, timeout drives the switch.
      do_reset();
      step(0, 1, 1, 0);
      idle(130);

      // Scenario 3: same-mode request.
      do_reset();
      step(0, 1, 0, 0);
      idle(5);

      // Scenario 4: two requests mid-sequence, latest (same mode) wins.
      do_reset();
      step(0, 1, 1, 0);
      idle(3);
      step(0, 0, 0, 1);
      idle(3);
      step(0, 1, 0, 0);
      idle(2);
      step(0, 1, 1, 0);
      idle(30);

      // Scenario 5: reverse request mid-sequence, second full sequence.
      do_reset();
      step(0, 1, 1, 0);
      idle(2);
      step(0, 0, 0, 1);
      idle(2);
      step(0, 1, 0, 0);
      idle(20);
      step(0, 0, 0, 1);
      idle(30);

      // Request landing in the RELEASE cycle.
      do_reset();
      step(0, 1, 1, 0);
      step(0, 0, 0, 1);
      idle(B + S + 1);
      step(0, 1, 0, 0);
      idle(5);
      step(0, 0, 0, 1);
      idle(20);

      // Scenario 6: reset during SETTLE, then a stray vsync.
      do_reset();
      step(0, 1, 1, 0);
      idle(2);
      step(0, 0, 0, 1);
      idle(B + 4);
      step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      idle(5);

      // Randomized traffic with alternating vsync density so timeouts also occur.
      do_reset();
      for (int blk = 0; blk < 6; blk++) begin
         int vs_div;
         vs_div = (blk % 2 == 0) ? 25 : 300;
         for (int i = 0; i < 500; i++) begin
            step(($urandom % 500) == 0,
                 ($urandom % 20) == 0,
                 $urandom[0],
                 ($urandom % vs_div) == 0);
         end
      end
      idle(3);

      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain leftover expected vectors got %0d required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
